// File: rtl/add_slice_sched_pkg.sv
// Shared types, defaults and helpers for the time-multiplexed slice adder.
package add_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/add_slice_sched_slice.sv
// Combinational W-bit ripple-carry adder slice built from one full adder per bit.
module add_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/add_slice_sched.sv
// Round-robin scheduler sharing one SLICE-bit adder among NREQ requesters;
// each WIDTH-bit add runs LSB slice first, one slice per cycle.
module add_slice_sched
  import add_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_cin,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_cout,
  output logic [clog2(NREQ)-1:0]  rsp_id
);

  localparam int IDW = clog2(NREQ);
  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (clog2(NSL) < 1) ? 1 : clog2(NSL);
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  state_t state, state_nxt;

  logic [NREQ-1:0][WIDTH-1:0] a_arr, b_arr;
  logic [IDW-1:0]   ptr, gnt_idx, id_q;
  logic             gnt_any, accept, run_en, last;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry, cout_q;
  logic [CW-1:0]    cnt;
  logic [SLICE-1:0] s_sum;
  logic             s_cout;
  logic [WIDTH+SLICE-1:0] sum_shift;

  assign a_arr = req_a;
  assign b_arr = req_b;

  // Round-robin search starting just past the last winner.
  always_comb begin
    int idx;
    logic [IDW-1:0] cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any)   state_nxt = RUN;
      RUN:     if (last)      state_nxt = HOLD;
      HOLD:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    run_en    = 1'b0;
    case (state)
      IDLE: if (gnt_any) begin
        req_ready[gnt_idx] = 1'b1;
        accept             = 1'b1;
      end
      RUN:     run_en = 1'b1;
      default: ;
    endcase
  end

  assign last = (cnt == LAST);

  // Operands shift down so the active slice always sits in the low bits.
  add_slice #(.W(SLICE)) u_slice (
    .a    (a_q[SLICE-1:0]),
    .b    (b_q[SLICE-1:0]),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout)
  );

  // Slice results enter at the top; after NSL steps slice 0 lands at bit 0.
  assign sum_shift = {s_sum, sum_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= IDW'(NREQ - 1);
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= a_arr[gnt_idx];
        b_q   <= b_arr[gnt_idx];
        carry <= req_cin[gnt_idx];
        id_q  <= gnt_idx;
        ptr   <= gnt_idx;
        cnt   <= '0;
      end
      if (run_en) begin
        a_q   <= a_q >> SLICE;
        b_q   <= b_q >> SLICE;
        sum_q <= sum_shift[WIDTH+SLICE-1:SLICE];
        carry <= s_cout;
        cnt   <= cnt + 1'b1;
        if (last) begin
          rsp_valid <= 1'b1;
          cout_q    <= s_cout;
        end
      end
      if (state == HOLD && rsp_ready) rsp_valid <= 1'b0;
    end
  end

  assign rsp_sum  = sum_q;
  assign rsp_cout = cout_q;
  assign rsp_id   = id_q;

endmodule
